// File: rtl/parity_frame_deserializer_pkg.sv
// Shared serial-frame constants: frame length, output-FSM encoding and frame layout.
package parity_frame_deserializer_pkg;

  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned BIT_CNT_W = $clog2(FRAME_LEN);
  localparam int unsigned DATA_BITS = FRAME_LEN - 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } frame_state_e;

  // First received bit sits in the LSB.
  typedef struct packed {
    logic p;
    logic z;
    logic y;
    logic x;
  } frame_t;

endpackage

// File: rtl/parity_frame_deserializer_parity.sv
// 4-bit even-parity checker: odd_c is high when the word holds an odd number of ones.
module parity_frame_deserializer_parity
  import parity_frame_deserializer_pkg::*;
(
  input  logic [FRAME_LEN-1:0] data,
  output logic                 odd_c
);

  assign odd_c = ^data;

endmodule

// File: rtl/parity_frame_deserializer.sv
// Collects 4-bit serial frames (X,Y,Z,P), presents them with a valid/ready handshake,
// flags parity errors, counts odd-parity frames and records dropped frames.
module parity_frame_deserializer
  import parity_frame_deserializer_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Serial_In,
  input  logic                 In_Valid,
  input  logic                 Frame_Ready,
  output logic                 X,
  output logic                 Y,
  output logic                 Z,
  output logic                 P,
  output logic                 Frame_Valid,
  output logic                 Parity_Err,
  output logic                 Overrun,
  output logic [ERR_CNT_W-1:0] Err_Count
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_LEN - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] data_q;
  frame_state_e         state;
  frame_state_e         state_next;
  frame_t               frame_q;
  frame_t               frame_c;
  logic                 parity_c;
  logic                 frame_done_c;
  logic                 load_c;
  logic                 drop_c;

  // Incoming word: three shifted-in bits plus the bit being sampled now as P.
  assign frame_c      = frame_t'({Serial_In, data_q});
  assign frame_done_c = In_Valid && (bit_cnt == LAST_BIT);

  parity_frame_deserializer_parity u_parity (
    .data  (frame_c),
    .odd_c (parity_c)
  );

  // Bit position and shift register; first bit ends up in data_q[0].
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bit_cnt <= '0;
      data_q  <= '0;
    end else if (In_Valid) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      data_q  <= {Serial_In, data_q[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A completed frame loads if the slot is empty or being consumed this edge.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    drop_c     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (frame_done_c) begin
          load_c     = 1'b1;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (frame_done_c) begin
          if (Frame_Ready) begin
            load_c = 1'b1;
          end else begin
            drop_c = 1'b1;
          end
        end else if (Frame_Ready) begin
          state_next = ST_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q    <= '0;
      Parity_Err <= 1'b0;
      Overrun    <= 1'b0;
      Err_Count  <= '0;
    end else begin
      if (load_c) begin
        frame_q    <= frame_c;
        Parity_Err <= parity_c;
        if (parity_c && (Err_Count != ERR_MAX)) begin
          Err_Count <= Err_Count + ERR_CNT_W'(1);
        end
      end
      if (drop_c) begin
        Overrun <= 1'b1;
      end
    end
  end

  assign X           = frame_q.x;
  assign Y           = frame_q.y;
  assign Z           = frame_q.z;
  assign P           = frame_q.p;
  assign Frame_Valid = (state == ST_FULL);

endmodule

// File: doc/parity_frame_deserializer.md
PARITY_FRAME_DESERIALIZER -- requirements
Module: parity_frame_deserializer

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, the width of the saturating parity-error counter.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Serial_In, input, 1, serial frame bit.
REQ-005 SHALL have port In_Valid, input, 1, Serial_In is sampled on an edge where this is high.
REQ-006 SHALL have port Frame_Ready, input, 1, downstream checker accepts the presented frame.
REQ-007 SHALL have port X, output, 1, frame data bit 0 (first bit received).
REQ-008 SHALL have port Y, output, 1, frame data bit 1.
REQ-009 SHALL have port Z, output, 1, frame data bit 2.
REQ-010 SHALL have port P, output, 1, frame parity bit (fourth bit received).
REQ-011 SHALL have port Frame_Valid, output, 1, X/Y/Z/P hold a complete, unconsumed frame.
REQ-012 SHALL have port Parity_Err, output, 1, X^Y^Z^P of the presented frame, valid while Frame_Valid is high.
REQ-013 SHALL have port Overrun, output, 1, sticky flag: a completed frame was dropped.
REQ-014 SHALL have port Err_Count, output, ERR_CNT_W, count of frames captured with odd parity.

Function
REQ-015 SHALL collect frames of exactly 4 sampled bits, in order X, Y, Z, P; edges with In_Valid low are ignored, with no timeout.
REQ-016 SHALL track position with a 2-bit bit counter 0..3 that wraps 3->0 on the fourth sampled bit.
REQ-017 SHALL use a two-state output FSM: EMPTY (Frame_Valid=0) and FULL (Frame_Valid=1).
REQ-018 On the edge sampling the fourth bit with the FSM in EMPTY, SHALL load X/Y/Z/P, register Parity_Err, and go to FULL; Frame_Valid rises one cycle after the fourth bit's edge.
REQ-019 SHALL complete the handshake on an edge where Frame_Valid and Frame_Ready are both high; FULL->EMPTY unless REQ-020 applies.
REQ-020 If a frame completes on the same edge as a handshake, SHALL load the new frame, stay FULL, and not set Overrun.
REQ-021 If a frame completes while FULL with no handshake, SHALL keep the presented frame unchanged, discard the new frame, and set Overrun.
REQ-022 Overrun SHALL remain set until Reset.
REQ-023 SHALL increment Err_Count by 1 for each frame loaded with odd parity, and not for dropped frames.
REQ-024 Err_Count SHALL saturate at 2^ERR_CNT_W-1.
REQ-025 X/Y/Z/P/Parity_Err SHALL be stable while Frame_Valid is high and no handshake occurs.
REQ-026 Frame_Ready while EMPTY SHALL have no effect.
REQ-027 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 On Reset high at an edge, SHALL clear the bit counter, FSM to EMPTY, X=Y=Z=P=0, Frame_Valid=0, Parity_Err=0, Overrun=0, Err_Count=0.
REQ-029 Reset SHALL take priority over any simultaneous In_Valid or Frame_Ready.
REQ-030 Reset mid-frame SHALL discard the partial bits; the next sampled bit is X.

Structure
REQ-031 Frame length (4) and FSM state encodings (EMPTY, FULL) SHALL live in a shared package with the team's other serial-frame constants.
REQ-032 The parity computation SHALL reuse the team's existing 4-bit even-parity checker, instantiated once on the shift-register contents.
REQ-033 The block SHALL contain no other sub-module.

Verification
REQ-034 Scenario, clean frame: bits 1,0,1,0 with In_Valid continuous and Frame_Ready=1 -> one-cycle Frame_Valid with X=1,Y=0,Z=1,P=0, Parity_Err=0, Err_Count=0.
REQ-035 Scenario, bad parity: bits 1,1,1,0 -> Parity_Err=1, Err_Count=1; then 0,0,0,1 -> Err_Count=2.
REQ-036 Scenario, gapped input: bits 0,1,1,0 with In_Valid low for 3 cycles between bits -> frame X=0,Y=1,Z=1,P=0 exactly one cycle after the fourth valid bit.
REQ-037 Scenario, backpressure: Frame_Ready=0, two back-to-back frames 1,0,0,1 then 0,1,0,1 -> first frame held, Overrun=1; assert Frame_Ready -> 1,0,0,1 consumed and Frame_Valid=0.
REQ-038 Scenario, simultaneous: Frame_Ready asserted on the same edge the second frame completes -> second frame presented, Overrun stays 0.
REQ-039 Scenarios, limits: Reset after 2 bits, then bits 1,1,0,0 -> frame X=1,Y=1,Z=0,P=0; with ERR_CNT_W=2, 5 odd frames -> Err_Count=3.
